smith_waterman_reader: RTL and testbench
========================================

SMITH_WATERMAN_READER -- requirements
Module: smith_waterman_reader

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 16, meaning the maximum number of in-flight read lines and the reorder-buffer (ROB) depth; power of two.
REQ-002 SHALL have port clk  input  1  the single clock.
REQ-003 SHALL have port SoftReset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that starts a fetch.
REQ-005 SHALL have port buf_addr  input  64 (t_hc_address)  byte address of the buffer, 64B-aligned.
REQ-006 SHALL have port num_lines  input  32  number of cache lines to fetch.
REQ-007 SHALL have port c0TxAlmFull  input  1  CCI-P channel-0 almost-full flag.
REQ-008 SHALL have port tx_c0  output  t_if_ccip_c0_Tx  read request channel.
REQ-009 SHALL have port rx_c0  input  t_if_ccip_c0_Rx  read response channel.
REQ-010 SHALL have ports out_valid  output  1, out_data  output  512 (t_block), out_last  output  1, and out_ready  input  1, forming the in-order stream to the scoring core.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the last line has been delivered.

Function
REQ-012 SHALL use t_rd_state with states S_RD_IDLE, S_RD_FETCH, S_RD_WAIT and S_RD_FINISH.
REQ-013 SHALL, in S_RD_IDLE on start, latch buf_addr[63:6] as the base CL address and latch num_lines; it SHALL go to S_RD_FETCH if num_lines is non-zero, else to S_RD_FINISH.
REQ-014 SHALL ignore start in any state other than S_RD_IDLE.
REQ-015 SHALL, in S_RD_FETCH, issue one request per cycle when all of the following hold: !c0TxAlmFull, outstanding < MAX_OUTSTANDING, and issued < num_lines.
REQ-016 SHALL form each request as: valid=1, vc_sel=eVC_VA, cl_len=eCL_LEN_1, req_type=eREQ_RDLINE_I, address=base+issued (42-bit wrap), mdata[log2(MAX_OUTSTANDING)-1:0]=issued low bits, other mdata bits 0.
REQ-017 SHALL register tx_c0 outputs; valid SHALL be 0 in every cycle with no issue.
REQ-018 SHALL go from S_RD_FETCH to S_RD_WAIT in the cycle the request with index num_lines-1 is issued.
REQ-019 SHALL accept a response when rx_c0.rspValid, resp_type==eRSP_RDLINE and state != S_RD_IDLE; it SHALL write data to ROB slot mdata low bits and set that slot's valid bit; responses may arrive in any order.
REQ-020 SHALL drive out_valid = valid bit of the head slot and out_data = that slot's data; the earliest out_valid is the cycle after the response.
REQ-021 SHALL, on out_valid && out_ready, clear the head valid bit, advance the head (mod MAX_OUTSTANDING) and increment drained.
REQ-022 SHALL assert out_last with out_valid when drained == num_lines-1.
REQ-023 SHALL compute outstanding = issued - drained in 32 bits; an issue and a drain in the same cycle SHALL leave outstanding unchanged.
REQ-024 SHALL go from S_RD_WAIT to S_RD_FINISH on the drain of the final line (drained reaching num_lines).
REQ-025 SHALL assert done for exactly one cycle in S_RD_FINISH and then return to S_RD_IDLE.
REQ-026 SHALL hold out_data stable while out_valid && !out_ready.
REQ-027 SHALL drop responses that arrive in S_RD_IDLE (stale responses after a reset).

Reset
REQ-028 SHALL, while SoftReset is high, force state=S_RD_IDLE, issued=drained=head=0, all ROB valid bits=0, tx_c0.valid=0, out_valid=0, out_last=0 and done=0.
REQ-029 SHALL abandon an in-progress fetch when reset is applied mid-operation, with no done pulse; ROB data contents are not reset.

Structure
REQ-030 SHALL take t_rd_state, t_block and t_hc_address from smith_waterman_pkg; constant MAX_OUTSTANDING default SHALL be added there as SW_RD_MAX_OUTSTANDING.
REQ-031 SHALL implement the ROB as sub-module smith_waterman_rob (MAX_OUTSTANDING x 512 storage, one write port, one read port, per-slot valid bits).

Verification
REQ-032 Bench SHALL cover: buf_addr=0x1000, num_lines=4, in-order responses, out_ready=1 -> requests to CL 0x40..0x43, 4 beats in order, out_last on beat 4, done one cycle later.
REQ-033 Bench SHALL cover: num_lines=8, responses returned in reverse mdata order -> output order is line 0..7 with no loss.
REQ-034 Bench SHALL cover: num_lines=40, no responses -> exactly 16 requests issued, then issue stalls until the first drain.
REQ-035 Bench SHALL cover: c0TxAlmFull high for 10 cycles during fetch -> no tx_c0.valid in those cycles, issue resumes afterwards.
REQ-036 Bench SHALL cover: start with num_lines=0 -> no requests, done pulse 2 cycles after start.
REQ-037 Bench SHALL cover: SoftReset after 3 of 8 lines drained, then late responses -> outputs at reset values, late responses ignored, next start fetches correctly.

Source files
------------

// File: rtl/smith_waterman_pkg.sv
// Shared types for the Smith-Waterman line reader.
// Holds the reader FSM state type, the 512-bit block and host address
// types, the default reorder depth, and the subset of CCI-P channel-0
// request/response types that the reader drives and consumes.
package smith_waterman_pkg;

    localparam int SW_RD_MAX_OUTSTANDING = 16;

    typedef logic [63:0]  t_hc_address;
    typedef logic [511:0] t_block;

    typedef enum logic [1:0] {
        S_RD_IDLE,
        S_RD_FETCH,
        S_RD_WAIT,
        S_RD_FINISH
    } t_rd_state;

    // CCI-P channel-0 subset
    typedef logic [41:0] t_ccip_clAddr;
    typedef logic [15:0] t_ccip_mdata;

    typedef enum logic [1:0] {
        eVC_VA  = 2'b00,
        eVC_VL0 = 2'b01,
        eVC_VH0 = 2'b10,
        eVC_VH1 = 2'b11
    } t_ccip_vc;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eREQ_RDLINE_I = 4'h0,
        eREQ_RDLINE_S = 4'h1
    } t_ccip_c0_req;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef struct packed {
        t_ccip_vc     vc_sel;
        logic [1:0]   rsvd1;
        t_ccip_clLen  cl_len;
        t_ccip_c0_req req_type;
        logic [5:0]   rsvd0;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_vc     vc_used;
        logic         rsvd1;
        logic         hit_miss;
        logic [1:0]   rsvd0;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_block             data;
        logic               rspValid;
    } t_if_ccip_c0_Rx;

endpackage

// File: rtl/smith_waterman_rob.sv
// Reorder buffer for the line reader: DEPTH slots of 512-bit data with a
// valid bit per slot. One write port (response side) sets a slot, one
// clear port (drain side) releases the slot being read.
//   clk, SoftReset : clock, synchronous active-high reset (valid bits only)
//   wr_en/wr_idx/wr_data : store a response and mark its slot valid
//   clr_en/clr_idx       : mark a slot empty after it has been consumed
//   rd_idx/rd_valid/rd_data : asynchronous view of one slot
module smith_waterman_rob
    import smith_waterman_pkg::*;
#(
    parameter int DEPTH = SW_RD_MAX_OUTSTANDING,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             SoftReset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  t_block           wr_data,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output t_block           rd_data
);

    logic [DEPTH-1:0] valid;
    t_block           mem [DEPTH];

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            valid <= '0;
        end else begin
            if (clr_en) valid[clr_idx] <= 1'b0;
            if (wr_en)  valid[wr_idx]  <= 1'b1;
        end
    end

    // Data storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_comb begin
        rd_valid = valid[rd_idx];
        rd_data  = mem[rd_idx];
    end

endmodule

// File: rtl/smith_waterman_reader.sv
// Streams num_lines consecutive cache lines starting at buf_addr to the
// scoring core, in address order, using up to MAX_OUTSTANDING CCI-P reads
// in flight. Responses may return out of order; mdata carries the ROB slot.
//   clk, SoftReset          : clock, synchronous active-high reset
//   start, buf_addr, num_lines : launch a fetch (sampled only when idle)
//   c0TxAlmFull, tx_c0      : channel-0 read requests (registered)
//   rx_c0                   : channel-0 read responses
//   out_valid/out_data/out_last/out_ready : in-order line stream
//   done                    : one-cycle pulse once the fetch has completed
module smith_waterman_reader
    import smith_waterman_pkg::*;
#(
    parameter int MAX_OUTSTANDING = SW_RD_MAX_OUTSTANDING
) (
    input  logic           clk,
    input  logic           SoftReset,
    input  logic           start,
    input  t_hc_address    buf_addr,
    input  logic [31:0]    num_lines,
    input  logic           c0TxAlmFull,
    output t_if_ccip_c0_Tx tx_c0,
    input  t_if_ccip_c0_Rx rx_c0,
    output logic           out_valid,
    output t_block         out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic           done
);

    localparam int IDX_W = $clog2(MAX_OUTSTANDING);

    t_rd_state        state;
    t_ccip_clAddr     base;
    logic [31:0]      num;
    logic [31:0]      issued;
    logic [31:0]      drained;
    logic [31:0]      outstanding;
    logic [IDX_W-1:0] head;
    logic             issue;
    logic             drain;
    logic             rsp_accept;
    logic             head_valid;
    logic             active;
    logic             unused_bits;

    always_comb begin
        outstanding = issued - drained;
        issue = (state == S_RD_FETCH) && !c0TxAlmFull &&
                (outstanding < 32'(MAX_OUTSTANDING)) && (issued < num);
        active = (state == S_RD_FETCH) || (state == S_RD_WAIT);
        out_valid = active && head_valid && !SoftReset;
        out_last  = out_valid && (drained == num - 32'd1);
        drain = out_valid && out_ready;
        rsp_accept = rx_c0.rspValid && (rx_c0.hdr.resp_type == eRSP_RDLINE) &&
                     (state != S_RD_IDLE) && !SoftReset;
        unused_bits = ^{buf_addr[63:48], buf_addr[5:0], rx_c0.hdr.vc_used,
                        rx_c0.hdr.rsvd1, rx_c0.hdr.hit_miss, rx_c0.hdr.rsvd0,
                        rx_c0.hdr.cl_num, rx_c0.hdr.mdata[15:IDX_W]};
    end

    smith_waterman_rob #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_rob (
        .clk      (clk),
        .SoftReset(SoftReset),
        .wr_en    (rsp_accept),
        .wr_idx   (rx_c0.hdr.mdata[IDX_W-1:0]),
        .wr_data  (rx_c0.data),
        .clr_en   (drain),
        .clr_idx  (head),
        .rd_idx   (head),
        .rd_valid (head_valid),
        .rd_data  (out_data)
    );

    always_ff @(posedge clk) begin
        if (SoftReset) begin
            state   <= S_RD_IDLE;
            base    <= '0;
            num     <= '0;
            issued  <= '0;
            drained <= '0;
            head    <= '0;
            done    <= 1'b0;
            tx_c0   <= '0;
        end else begin
            tx_c0.valid <= issue;
            if (issue) begin
                tx_c0.hdr          <= '0;
                tx_c0.hdr.vc_sel   <= eVC_VA;
                tx_c0.hdr.cl_len   <= eCL_LEN_1;
                tx_c0.hdr.req_type <= eREQ_RDLINE_I;
                tx_c0.hdr.address  <= base + issued[41:0];
                tx_c0.hdr.mdata[IDX_W-1:0] <= issued[IDX_W-1:0];
                issued <= issued + 32'd1;
            end
            if (drain) begin
                drained <= drained + 32'd1;
                head    <= head + 1'b1;
            end

            case (state)
                S_RD_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base    <= buf_addr[47:6];
                        num     <= num_lines;
                        issued  <= '0;
                        drained <= '0;
                        head    <= '0;
                        state   <= (num_lines != 32'd0) ? S_RD_FETCH : S_RD_FINISH;
                    end
                end
                S_RD_FETCH: begin
                    if (issue && (issued == num - 32'd1)) state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Raise done together with the last drain so the pulse
                    // lines up with the single FINISH cycle that follows.
                    if (drain && (drained == num - 32'd1)) begin
                        state <= S_RD_FINISH;
                        done  <= 1'b1;
                    end
                end
                S_RD_FINISH: begin
                    // Entered without done (zero-line fetch): spend one extra
                    // FINISH cycle raising it; otherwise drop it and go idle.
                    if (done) begin
                        done  <= 1'b0;
                        state <= S_RD_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= S_RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smith_waterman_reader.sv
module tb_smith_waterman_reader;
    import smith_waterman_pkg::*;

    logic           clk = 1'b0;
    logic           SoftReset;
    logic           start;
    t_hc_address    buf_addr;
    logic [31:0]    num_lines;
    logic           c0TxAlmFull;
    t_if_ccip_c0_Tx tx_c0;
    t_if_ccip_c0_Rx rx_c0;
    logic           out_valid;
    t_block         out_data;
    logic           out_last;
    logic           out_ready;
    logic           done;

    always #5 clk = ~clk;

    smith_waterman_reader #(
        .MAX_OUTSTANDING(16)
    ) dut (
        .clk        (clk),
        .SoftReset  (SoftReset),
        .start      (start),
        .buf_addr   (buf_addr),
        .num_lines  (num_lines),
        .c0TxAlmFull(c0TxAlmFull),
        .tx_c0      (tx_c0),
        .rx_c0      (rx_c0),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .done       (done)
    );

    typedef struct {
        t_block data;
        logic   last;
        int     c;
    } beat_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int req_total = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    t_ccip_c0_ReqMemHdr req_q[$];
    beat_t              beat_q[$];
    t_block             exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: records issued requests, accepted beats, done pulses.
    always @(negedge clk) begin
        if (tx_c0.valid === 1'b1) begin
            req_q.push_back(tx_c0.hdr);
            req_total++;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            beat_t b;
            b.data = out_data;
            b.last = out_last;
            b.c    = cyc;
            beat_q.push_back(b);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    function automatic t_block line_data(input logic [41:0] a);
        t_block d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = {a[21:0], 10'(k)} ^ 32'h5A5A_C3C3;
        return d;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input t_hc_address a, input int n);
        logic [41:0] cl;
        cl = a[47:6];
        buf_addr  = a;
        num_lines = n;
        for (int i = 0; i < n; i++) exp_q.push_back(line_data(cl + 42'(i)));
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic respond(input t_ccip_c0_ReqMemHdr h);
        rx_c0 = '0;
        rx_c0.rspValid      = 1'b1;
        rx_c0.hdr.resp_type = eRSP_RDLINE;
        rx_c0.hdr.mdata     = h.mdata;
        rx_c0.data          = line_data(h.address);
        tick;
        rx_c0.rspValid = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input int budget, output bit ok);
        int b = 0;
        while (req_q.size() < n && b < budget) begin
            tick;
            b++;
        end
        ok = (req_q.size() >= n);
    endtask

    // In-order responder: answers outstanding requests until n beats seen.
    task automatic serve(input int n_beats, input int budget, output bit ok);
        int b = 0;
        while (beat_q.size() < n_beats && b < budget) begin
            if (req_q.size() > 0) respond(req_q.pop_front());
            else tick;
            b++;
        end
        ok = (beat_q.size() >= n_beats);
    endtask

    task automatic test_reset;
        SoftReset = 1'b1;
        repeat (3) tick;
        total++; if (tx_c0.valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b want=0", tx_c0.valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_out_last got=%b want=0", out_last); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        SoftReset = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        bit ok;
        int r0, d0, last_c;
        t_ccip_c0_ReqMemHdr h;
        r0 = req_total; d0 = done_cnt; last_c = 0;
        out_ready = 1'b1;
        launch(64'h1000, 4);
        wait_reqs(4, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_req_timeout got=%0d want=4", req_q.size()); end
        for (int i = 0; i < 4 && i < req_q.size(); i++) begin
            h = req_q[i];
            total++; if (h.address !== 42'(64'h40 + i)) begin bad++; $display("FAIL basic_addr%0d got=%h want=%h", i, h.address, 64'h40 + i); end
            total++; if (h.mdata !== 16'(i)) begin bad++; $display("FAIL basic_mdata%0d got=%h want=%h", i, h.mdata, i); end
            total++; if ({h.vc_sel, h.cl_len, h.req_type} !== {eVC_VA, eCL_LEN_1, eREQ_RDLINE_I})
                begin bad++; $display("FAIL basic_fields%0d got=%h want=%h", i, {h.vc_sel, h.cl_len, h.req_type}, {eVC_VA, eCL_LEN_1, eREQ_RDLINE_I}); end
        end
        serve(4, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_beat_timeout got=%0d want=4", beat_q.size()); end
        repeat (4) tick;
        for (int i = 0; i < 4 && beat_q.size() > 0 && exp_q.size() > 0; i++) begin
            beat_t bt;
            t_block e;
            bt = beat_q.pop_front();
            e  = exp_q.pop_front();
            last_c = bt.c;
            total++; if (bt.data !== e) begin bad++; $display("FAIL basic_data%0d got=%h want=%h", i, bt.data, e); end
            total++; if (bt.last !== (i == 3)) begin bad++; $display("FAIL basic_last%0d got=%b want=%b", i, bt.last, i == 3); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - d0); end
        total++; if (done_cyc - last_c !== 1) begin bad++; $display("FAIL basic_done_delay got=%0d want=1", done_cyc - last_c); end
        total++; if (req_total - r0 !== 4) begin bad++; $display("FAIL basic_req_count got=%0d want=4", req_total - r0); end
    endtask

    task automatic test_reorder;
        bit ok;
        int d0;
        d0 = done_cnt;
        out_ready = 1'b1;
        launch(64'h0001_2340, 8);
        wait_reqs(8, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL reorder_req_timeout got=%0d want=8", req_q.size()); end
        for (int i = 7; i >= 0; i--) if (i < req_q.size()) respond(req_q[i]);
        req_q.delete();
        serve(8, 50, ok);
        total++; if (!ok) begin bad++; $display("FAIL reorder_beat_timeout got=%0d want=8", beat_q.size()); end
        repeat (4) tick;
        for (int i = 0; i < 8 && beat_q.size() > 0 && exp_q.size() > 0; i++) begin
            beat_t bt;
            t_block e;
            bt = beat_q.pop_front();
            e  = exp_q.pop_front();
            total++; if (bt.data !== e) begin bad++; $display("FAIL reorder_data%0d got=%h want=%h", i, bt.data, e); end
            total++; if (bt.last !== (i == 7)) begin bad++; $display("FAIL reorder_last%0d got=%b want=%b", i, bt.last, i == 7); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL reorder_done got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_backpressure_limit;
        bit ok;
        int r0, d0;
        t_ccip_c0_ReqMemHdr h;
        r0 = req_total; d0 = done_cnt;
        out_ready = 1'b1;
        launch(64'h0004_0000, 40);
        repeat (40) tick;
        total++; if (req_total - r0 !== 16) begin bad++; $display("FAIL limit_stall got=%0d want=16", req_total - r0); end
        h = req_q.pop_front();
        respond(h);
        repeat (8) tick;
        total++; if (req_total - r0 !== 17) begin bad++; $display("FAIL limit_resume got=%0d want=17", req_total - r0); end
        if (req_q.size() > 0) begin
            h = req_q[req_q.size()-1];
            total++; if (h.address !== 42'(64'h1000 + 16)) begin bad++; $display("FAIL limit_addr16 got=%h want=%h", h.address, 64'h1010); end
            total++; if (h.mdata !== 16'h0) begin bad++; $display("FAIL limit_mdata16 got=%h want=0", h.mdata); end
        end
        serve(40, 600, ok);
        total++; if (!ok) begin bad++; $display("FAIL limit_beat_timeout got=%0d want=40", beat_q.size()); end
        repeat (4) tick;
        for (int i = 0; i < 40 && beat_q.size() > 0 && exp_q.size() > 0; i++) begin
            beat_t bt;
            t_block e;
            bt = beat_q.pop_front();
            e  = exp_q.pop_front();
            total++; if (bt.data !== e) begin bad++; $display("FAIL limit_data%0d got=%h want=%h", i, bt.data, e); end
            total++; if (bt.last !== (i == 39)) begin bad++; $display("FAIL limit_last%0d got=%b want=%b", i, bt.last, i == 39); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL limit_done got=%0d want=1", done_cnt - d0); end
    endtask

    task automatic test_almfull;
        bit ok;
        int viol;
        viol = 0;
        out_ready = 1'b1;
        launch(64'h0008_0000, 8);
        tick;
        tick;
        c0TxAlmFull = 1'b1;
        tick;
        for (int i = 0; i < 10; i++) begin
            if (tx_c0.valid !== 1'b0) viol++;
            if (i == 9) c0TxAlmFull = 1'b0;
            tick;
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL almfull_quiet got=%0d want=0", viol); end
        serve(8, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL almfull_resume got=%0d want=8", beat_q.size()); end
        repeat (4) tick;
        for (int i = 0; i < 8 && beat_q.size() > 0 && exp_q.size() > 0; i++) begin
            beat_t bt;
            t_block e;
            bt = beat_q.pop_front();
            e  = exp_q.pop_front();
            total++; if (bt.data !== e) begin bad++; $display("FAIL almfull_data%0d got=%h want=%h", i, bt.data, e); end
        end
    endtask

    task automatic test_zero_lines;
        int r0;
        logic d1, d2, d3;
        r0 = req_total;
        launch(64'h0000_2000, 0);
        d1 = done;
        tick;
        d2 = done;
        tick;
        d3 = done;
        tick;
        total++; if (d1 !== 1'b0) begin bad++; $display("FAIL zero_done_c1 got=%b want=0", d1); end
        total++; if (d2 !== 1'b1) begin bad++; $display("FAIL zero_done_c2 got=%b want=1", d2); end
        total++; if (d3 !== 1'b0) begin bad++; $display("FAIL zero_done_c3 got=%b want=0", d3); end
        total++; if (req_total - r0 !== 0) begin bad++; $display("FAIL zero_reqs got=%0d want=0", req_total - r0); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int r0, d0, ov;
        out_ready = 1'b0;
        launch(64'h000C_0000, 8);
        wait_reqs(8, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_req_timeout got=%0d want=8", req_q.size()); end
        for (int i = 0; i < 5 && req_q.size() > 0; i++) respond(req_q.pop_front());
        tick;
        out_ready = 1'b1;
        repeat (3) tick;
        out_ready = 1'b0;
        tick;
        total++; if (beat_q.size() !== 3) begin bad++; $display("FAIL midrst_drained got=%0d want=3", beat_q.size()); end
        for (int i = 0; i < 3 && beat_q.size() > 0 && exp_q.size() > 0; i++) begin
            beat_t bt;
            t_block e;
            bt = beat_q.pop_front();
            e  = exp_q.pop_front();
            total++; if (bt.data !== e) begin bad++; $display("FAIL midrst_data%0d got=%h want=%h", i, bt.data, e); end
        end
        exp_q.delete();
        d0 = done_cnt;
        SoftReset = 1'b1;
        tick;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL midrst_out_last got=%b want=0", out_last); end
        total++; if (tx_c0.valid !== 1'b0) begin bad++; $display("FAIL midrst_tx_valid got=%b want=0", tx_c0.valid); end
        tick;
        SoftReset = 1'b0;
        tick;
        r0 = req_total;
        ov = 0;
        out_ready = 1'b1;
        while (req_q.size() > 0) begin
            respond(req_q.pop_front());
            if (out_valid !== 1'b0) ov++;
        end
        repeat (4) begin
            tick;
            if (out_valid !== 1'b0) ov++;
        end
        total++; if (ov !== 0) begin bad++; $display("FAIL midrst_stale_valid got=%0d want=0", ov); end
        total++; if (beat_q.size() !== 0) begin bad++; $display("FAIL midrst_stale_beats got=%0d want=0", beat_q.size()); end
        total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", done_cnt - d0); end
        total++; if (req_total - r0 !== 0) begin bad++; $display("FAIL midrst_no_reqs got=%0d want=0", req_total - r0); end
        beat_q.delete();
        launch(64'h0010_0000, 4);
        serve(4, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL midrst_refetch_timeout got=%0d want=4", beat_q.size()); end
        repeat (4) tick;
        for (int i = 0; i < 4 && beat_q.size() > 0 && exp_q.size() > 0; i++) begin
            beat_t bt;
            t_block e;
            bt = beat_q.pop_front();
            e  = exp_q.pop_front();
            total++; if (bt.data !== e) begin bad++; $display("FAIL midrst_refetch_data%0d got=%h want=%h", i, bt.data, e); end
            total++; if (bt.last !== (i == 3)) begin bad++; $display("FAIL midrst_refetch_last%0d got=%b want=%b", i, bt.last, i == 3); end
        end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL midrst_refetch_done got=%0d want=1", done_cnt - d0); end
    endtask

    initial begin
        SoftReset   = 1'b1;
        start       = 1'b0;
        buf_addr    = '0;
        num_lines   = '0;
        c0TxAlmFull = 1'b0;
        out_ready   = 1'b1;
        rx_c0       = '0;
        test_reset;
        test_basic;
        test_reorder;
        test_backpressure_limit;
        test_almfull;
        test_zero_lines;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
